// File: rtl/cgra_context_memory_banked.sv
// Banked per-row context memory: a beat-assembling loader broadcasts lines into
// flip-flop banks, and each row has its own 1-cycle synchronous read port.
module cgra_context_memory_banked #(
   parameter int unsigned N_ROW       = 4,
   parameter int unsigned N_LINES     = 64,
   parameter int unsigned INSTR_WIDTH = 32,
   parameter int unsigned BUS_WIDTH   = 32,
   localparam int unsigned ADDR_W     = $clog2(N_LINES)
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           wr_start_i,
   input  logic [ADDR_W-1:0]              wr_addr_i,
   input  logic                           wr_valid_i,
   output logic                           wr_ready_o,
   input  logic [BUS_WIDTH-1:0]           wr_data_i,
   input  logic [N_ROW-1:0]               wr_row_mask_i,
   output logic [ADDR_W-1:0]              wr_ptr_o,
   output logic                           wr_busy_o,
   output logic                           wr_wrap_o,
   input  logic [N_ROW-1:0]               rd_req_i,
   input  logic [N_ROW*ADDR_W-1:0]        rd_addr_i,
   output logic [N_ROW*INSTR_WIDTH-1:0]   rd_data_o,
   output logic [N_ROW-1:0]               rd_valid_o
);

   localparam int unsigned BEATS  = (INSTR_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH;
   localparam int unsigned LINE_W = BEATS * BUS_WIDTH;
   localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

   localparam logic [ADDR_W-1:0] LAST_LINE = ADDR_W'(N_LINES - 1);
   localparam logic [ADDR_W:0]   LINES_EXT = (ADDR_W + 1)'(N_LINES);
   localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);

   typedef enum logic [1:0] {
      StIdle,
      StCollect,
      StCommit
   } state_e;

   state_e             r_state;
   state_e             w_state_d;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cnt_d;
   logic [ADDR_W-1:0]  r_ptr;
   logic [ADDR_W-1:0]  w_ptr_d;
   logic [N_ROW-1:0]   r_mask;
   logic [N_ROW-1:0]   w_mask_d;
   logic               r_wrap;
   logic               w_wrap_d;
   logic               r_busy;
   logic               w_busy_d;
   logic [LINE_W-1:0]  r_line;

   logic               w_accept;
   logic               w_last;
   logic               w_we;
   logic [ADDR_W-1:0]  w_start_addr;

   assign wr_ready_o   = (r_state != StCommit) & ~wr_start_i;
   assign w_accept     = wr_valid_i & wr_ready_o;
   assign w_last       = (r_cnt == LAST_BEAT);
   // Out-of-range start addresses fold to line 0.
   assign w_start_addr = ({1'b0, wr_addr_i} < LINES_EXT) ? wr_addr_i : '0;
   // A reset sampled on the commit edge suppresses the bank write.
   assign w_we         = (r_state == StCommit) & rst_ni;

   assign wr_ptr_o  = r_ptr;
   assign wr_busy_o = r_busy;
   assign wr_wrap_o = r_wrap;

   always_comb begin
      w_state_d = r_state;
      w_cnt_d   = r_cnt;
      w_ptr_d   = r_ptr;
      w_mask_d  = r_mask;
      w_wrap_d  = 1'b0;
      unique case (r_state)
         StIdle, StCollect: begin
            if (wr_start_i) begin
               w_state_d = StIdle;
               w_cnt_d   = '0;
               w_ptr_d   = w_start_addr;
            end else if (w_accept) begin
               if (w_last) begin
                  w_state_d = StCommit;
                  w_cnt_d   = '0;
                  w_mask_d  = wr_row_mask_i;
               end else begin
                  w_state_d = StCollect;
                  w_cnt_d   = r_cnt + CNT_W'(1);
               end
            end
         end
         StCommit: begin
            w_state_d = StIdle;
            w_wrap_d  = (r_ptr == LAST_LINE);
            if (wr_start_i) begin
               w_ptr_d = w_start_addr;
            end else if (r_ptr == LAST_LINE) begin
               w_ptr_d = '0;
            end else begin
               w_ptr_d = r_ptr + ADDR_W'(1);
            end
         end
         default: begin
            w_state_d = StIdle;
            w_cnt_d   = '0;
         end
      endcase
      w_busy_d = (w_state_d != StIdle);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state <= StIdle;
         r_cnt   <= '0;
         r_ptr   <= '0;
         r_mask  <= '0;
         r_wrap  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_d;
         r_cnt   <= w_cnt_d;
         r_ptr   <= w_ptr_d;
         r_mask  <= w_mask_d;
         r_wrap  <= w_wrap_d;
         r_busy  <= w_busy_d;
      end
   end

   // Beat k lands in slice k; stale beats are simply overwritten on the next line.
   always_ff @(posedge clk_i) begin
      if (w_accept) begin
         for (int k = 0; k < BEATS; k++) begin
            if (r_cnt == CNT_W'(k)) begin
               r_line[k*BUS_WIDTH +: BUS_WIDTH] <= wr_data_i;
            end
         end
      end
   end

   for (genvar g = 0; g < N_ROW; g++) begin : g_row
      logic [INSTR_WIDTH-1:0] r_bank [N_LINES];
      logic [INSTR_WIDTH-1:0] r_rd_data;
      logic                   r_rd_valid;
      logic [ADDR_W-1:0]      w_rd_addr;

      assign w_rd_addr = rd_addr_i[g*ADDR_W +: ADDR_W];

      always_ff @(posedge clk_i) begin
         if (w_we && r_mask[g]) begin
            r_bank[r_ptr] <= r_line[INSTR_WIDTH-1:0];
         end
      end

      // Shares the edge with the bank write, so a same-line read sees old data.
      always_ff @(posedge clk_i) begin
         if (!rst_ni) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
         end else begin
            r_rd_valid <= rd_req_i[g];
            if (rd_req_i[g]) begin
               r_rd_data <= ({1'b0, w_rd_addr} < LINES_EXT) ? r_bank[w_rd_addr] : '0;
            end
         end
      end

      assign rd_data_o[g*INSTR_WIDTH +: INSTR_WIDTH] = r_rd_data;
      assign rd_valid_o[g]                           = r_rd_valid;
   end

endmodule

// File: tb/tb_cgra_context_memory_banked.sv
// Bench for the banked context memory: a default 32/32 instance and a 48/32,
// 40-line instance, with read responses checked through per-instance queues.
module tb_cgra_context_memory_banked;

   typedef struct {
      int          row;
      logic [47:0] data;
   } rd_exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   rd_exp_t q_a[$];
   rd_exp_t q_b[$];
   rd_exp_t e_a;
   rd_exp_t e_b;

   // Instance A: default parameters.
   logic          rst_a_n = 1'b0;
   logic          start_a = 1'b0;
   logic [5:0]    addr_a = '0;
   logic          valid_a = 1'b0;
   logic          ready_a;
   logic [31:0]   data_a = '0;
   logic [3:0]    mask_a = '0;
   logic [5:0]    ptr_a;
   logic          busy_a;
   logic          wrap_a;
   logic [3:0]    rd_req_a = '0;
   logic [23:0]   rd_addr_a = '0;
   logic [127:0]  rd_data_a;
   logic [3:0]    rd_valid_a;

   // Instance B: 48-bit lines over a 32-bit bus, 40 lines.
   logic          rst_b_n = 1'b0;
   logic          start_b = 1'b0;
   logic [5:0]    addr_b = '0;
   logic          valid_b = 1'b0;
   logic          ready_b;
   logic [31:0]   data_b = '0;
   logic [3:0]    mask_b = '0;
   logic [5:0]    ptr_b;
   logic          busy_b;
   logic          wrap_b;
   logic [3:0]    rd_req_b = '0;
   logic [23:0]   rd_addr_b = '0;
   logic [191:0]  rd_data_b;
   logic [3:0]    rd_valid_b;

   cgra_context_memory_banked u_dut_a (
      .clk_i         (clk),
      .rst_ni        (rst_a_n),
      .wr_start_i    (start_a),
      .wr_addr_i     (addr_a),
      .wr_valid_i    (valid_a),
      .wr_ready_o    (ready_a),
      .wr_data_i     (data_a),
      .wr_row_mask_i (mask_a),
      .wr_ptr_o      (ptr_a),
      .wr_busy_o     (busy_a),
      .wr_wrap_o     (wrap_a),
      .rd_req_i      (rd_req_a),
      .rd_addr_i     (rd_addr_a),
      .rd_data_o     (rd_data_a),
      .rd_valid_o    (rd_valid_a)
   );

   cgra_context_memory_banked #(
      .N_ROW       (4),
      .N_LINES     (40),
      .INSTR_WIDTH (48),
      .BUS_WIDTH   (32)
   ) u_dut_b (
      .clk_i         (clk),
      .rst_ni        (rst_b_n),
      .wr_start_i    (start_b),
      .wr_addr_i     (addr_b),
      .wr_valid_i    (valid_b),
      .wr_ready_o    (ready_b),
      .wr_data_i     (data_b),
      .wr_row_mask_i (mask_b),
      .wr_ptr_o      (ptr_b),
      .wr_busy_o     (busy_b),
      .wr_wrap_o     (wrap_b),
      .rd_req_i      (rd_req_b),
      .rd_addr_i     (rd_addr_b),
      .rd_data_o     (rd_data_b),
      .rd_valid_o    (rd_valid_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic start_at_a(input logic [5:0] a);
      start_a = 1'b1;
      addr_a  = a;
      tick();
      start_a = 1'b0;
   endtask

   task automatic start_at_b(input logic [5:0] a);
      start_b = 1'b1;
      addr_b  = a;
      tick();
      start_b = 1'b0;
   endtask

   // Valid stays high through COMMIT so a wrongly accepted beat shows up.
   task automatic beat_a(input logic [31:0] d, input logic [3:0] m);
      valid_a = 1'b1;
      data_a  = d;
      mask_a  = m;
      tick();
      chk("a_ready_in_commit", 64'(ready_a), 64'd0);
      tick();
      valid_a = 1'b0;
   endtask

   // Mask is inverted on the first beat: only the last-beat mask may count.
   task automatic line_b(input logic [31:0] d0, input logic [31:0] d1, input logic [3:0] m);
      valid_b = 1'b1;
      data_b  = d0;
      mask_b  = ~m;
      tick();
      chk("b_busy_collect", 64'(busy_b), 64'd1);
      chk("b_ready_collect", 64'(ready_b), 64'd1);
      data_b = d1;
      mask_b = m;
      tick();
      chk("b_ready_in_commit", 64'(ready_b), 64'd0);
      tick();
      valid_b = 1'b0;
   endtask

   task automatic rd_a(input logic [3:0] req, input logic [23:0] addrs,
                       input logic [31:0] e0, input logic [31:0] e1,
                       input logic [31:0] e2, input logic [31:0] e3);
      logic [31:0] ev [4];
      ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3;
      rd_req_a  = req;
      rd_addr_a = addrs;
      for (int r = 0; r < 4; r++) begin
         if (req[r]) q_a.push_back('{row: r, data: 48'(ev[r])});
      end
      tick();
      rd_req_a = '0;
   endtask

   task automatic rd_b(input logic [3:0] req, input logic [23:0] addrs,
                       input logic [47:0] e0, input logic [47:0] e1,
                       input logic [47:0] e2, input logic [47:0] e3);
      logic [47:0] ev [4];
      ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3;
      rd_req_b  = req;
      rd_addr_b = addrs;
      for (int r = 0; r < 4; r++) begin
         if (req[r]) q_b.push_back('{row: r, data: ev[r]});
      end
      tick();
      rd_req_b = '0;
   endtask

   always @(negedge clk) begin
      for (int r = 0; r < 4; r++) begin
         if (rd_valid_a[r]) begin
            n_vec++;
            if (q_a.size() == 0) begin
               n_err++;
               $display("FAIL a_rd_unexpected: row %0d data %0h, expected no response",
                        r, rd_data_a[r*32 +: 32]);
            end else begin
               e_a = q_a.pop_front();
               if (e_a.row != r || rd_data_a[r*32 +: 32] !== e_a.data[31:0]) begin
                  n_err++;
                  $display("FAIL a_rd_data: row %0d data %0h, expected row %0d data %0h",
                           r, rd_data_a[r*32 +: 32], e_a.row, e_a.data[31:0]);
               end
            end
         end
         if (rd_valid_b[r]) begin
            n_vec++;
            if (q_b.size() == 0) begin
               n_err++;
               $display("FAIL b_rd_unexpected: row %0d data %0h, expected no response",
                        r, rd_data_b[r*48 +: 48]);
            end else begin
               e_b = q_b.pop_front();
               if (e_b.row != r || rd_data_b[r*48 +: 48] !== e_b.data) begin
                  n_err++;
                  $display("FAIL b_rd_data: row %0d data %0h, expected row %0d data %0h",
                           r, rd_data_b[r*48 +: 48], e_b.row, e_b.data);
               end
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, expected $finish");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset values.
      tick();
      tick();
      chk("a_rst_ptr", 64'(ptr_a), 64'd0);
      chk("a_rst_ready", 64'(ready_a), 64'd1);
      chk("a_rst_busy", 64'(busy_a), 64'd0);
      chk("a_rst_wrap", 64'(wrap_a), 64'd0);
      chk("a_rst_rd_valid", 64'(rd_valid_a), 64'd0);
      chk("a_rst_rd_data", 64'(|rd_data_a), 64'd0);
      chk("b_rst_ptr", 64'(ptr_b), 64'd0);
      rst_a_n = 1'b1;
      rst_b_n = 1'b1;

      // Streamed load of lines 5..8 into all rows.
      start_at_a(6'd5);
      chk("a_ptr_after_start", 64'(ptr_a), 64'd5);
      for (int i = 0; i < 4; i++) beat_a(32'hA0 + 32'(i), 4'b1111);
      chk("a_ptr_after_load", 64'(ptr_a), 64'd9);
      chk("a_busy_idle", 64'(busy_a), 64'd0);
      rd_a(4'b1111, {6'd7, 6'd7, 6'd7, 6'd7}, 32'hA2, 32'hA2, 32'hA2, 32'hA2);
      rd_a(4'b1111, {6'd7, 6'd8, 6'd6, 6'd5}, 32'hA0, 32'hA1, 32'hA3, 32'hA2);

      // Zero mask writes nothing but still advances.
      start_at_a(6'd20);
      beat_a(32'h7777, 4'b1111);
      start_at_a(6'd20);
      beat_a(32'h8888, 4'b0000);
      chk("a_ptr_zero_mask", 64'(ptr_a), 64'd21);
      rd_a(4'b1001, {6'd20, 6'd0, 6'd0, 6'd20}, 32'h7777, 32'h0, 32'h0, 32'h7777);

      // Wrap from line 63 to 0.
      start_at_a(6'd63);
      beat_a(32'hB0, 4'b0001);
      chk("a_wrap_pulse", 64'(wrap_a), 64'd1);
      chk("a_ptr_wrapped", 64'(ptr_a), 64'd0);
      tick();
      chk("a_wrap_one_cycle", 64'(wrap_a), 64'd0);
      beat_a(32'hB1, 4'b0001);
      chk("a_wrap_second", 64'(wrap_a), 64'd0);
      chk("a_ptr_after_wrap", 64'(ptr_a), 64'd1);
      rd_a(4'b0011, {6'd0, 6'd0, 6'd5, 6'd63}, 32'hB0, 32'hA0, 32'h0, 32'h0);
      rd_a(4'b0001, {6'd0, 6'd0, 6'd0, 6'd0}, 32'hB1, 32'h0, 32'h0, 32'h0);

      // Read-before-write on row 2, line 3.
      start_at_a(6'd3);
      beat_a(32'h1234, 4'b1111);
      start_at_a(6'd3);
      valid_a = 1'b1;
      data_a  = 32'hBEEF;
      mask_a  = 4'b1111;
      tick();
      rd_req_a  = 4'b0100;
      rd_addr_a = {6'd0, 6'd3, 6'd0, 6'd0};
      q_a.push_back('{row: 2, data: 48'h1234});
      tick();
      rd_req_a = '0;
      valid_a  = 1'b0;
      rd_a(4'b0100, {6'd0, 6'd3, 6'd0, 6'd0}, 32'h0, 32'h0, 32'hBEEF, 32'h0);

      // Reset during COMMIT with reads held on.
      start_at_a(6'd10);
      beat_a(32'h5555, 4'b1111);
      start_at_a(6'd10);
      valid_a = 1'b1;
      data_a  = 32'hDEAD;
      mask_a  = 4'b1111;
      tick();
      rd_req_a  = 4'b1111;
      rd_addr_a = {6'd10, 6'd10, 6'd10, 6'd10};
      rst_a_n   = 1'b0;
      valid_a   = 1'b0;
      tick();
      chk("a_mid_rst_ptr", 64'(ptr_a), 64'd0);
      chk("a_mid_rst_ready", 64'(ready_a), 64'd1);
      chk("a_mid_rst_busy", 64'(busy_a), 64'd0);
      chk("a_mid_rst_wrap", 64'(wrap_a), 64'd0);
      chk("a_mid_rst_rd_valid", 64'(rd_valid_a), 64'd0);
      chk("a_mid_rst_rd_data", 64'(|rd_data_a), 64'd0);
      rst_a_n = 1'b1;
      for (int r = 0; r < 4; r++) q_a.push_back('{row: r, data: 48'h5555});
      tick();
      rd_req_a = '0;
      tick();

      // Two-beat lines on instance B.
      start_at_b(6'd0);
      line_b(32'hAAAA0001, 32'h0000BBBB, 4'b0001);
      start_at_b(6'd0);
      line_b(32'h11112222, 32'hFFFF3333, 4'b0010);
      chk("b_ptr_after_lines", 64'(ptr_b), 64'd1);
      rd_b(4'b0011, {6'd0, 6'd0, 6'd0, 6'd0},
           48'hBBBB_AAAA_0001, 48'h3333_1111_2222, 48'h0, 48'h0);

      // Abort a partial line; start beats a simultaneous valid beat.
      valid_b = 1'b1;
      data_b  = 32'hDEADBEEF;
      mask_b  = 4'b1111;
      tick();
      data_b  = 32'h99999999;
      start_b = 1'b1;
      addr_b  = 6'd10;
      #1;
      chk("b_ready_on_start", 64'(ready_b), 64'd0);
      tick();
      start_b = 1'b0;
      valid_b = 1'b0;
      chk("b_ptr_after_abort", 64'(ptr_b), 64'd10);
      chk("b_busy_after_abort", 64'(busy_b), 64'd0);
      line_b(32'h44445555, 32'h00006666, 4'b0100);
      chk("b_ptr_after_abort_line", 64'(ptr_b), 64'd11);
      rd_b(4'b1100, {6'd50, 6'd10, 6'd0, 6'd0},
           48'h0, 48'h0, 48'h6666_4444_5555, 48'h0);

      // Out-of-range start address folds to 0.
      start_at_b(6'd45);
      chk("b_ptr_oob_start", 64'(ptr_b), 64'd0);

      tick();
      tick();
      chk("a_queue_drained", 64'(q_a.size()), 64'd0);
      chk("b_queue_drained", 64'(q_b.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
